// File: rtl/vga_timing_gen_if.sv
// Pixel-coordinate bundle shared between the raster timing generator and
// the sprite/background drawers that consume it.
interface vga_timing_gen_if;
  logic [9:0] DrawX;
  logic [9:0] DrawY;
  logic       blank;
  logic       hs;
  logic       vs;
  logic       frame_start;
  logic [7:0] frame_count;

  // Timing generator side: produces coordinates, syncs and frame strobe
  modport master (
    output DrawX,
    output DrawY,
    output blank,
    output hs,
    output vs,
    output frame_start,
    output frame_count
  );

  // Drawer side: consumes coordinates, syncs and frame strobe
  modport slave (
    input DrawX,
    input DrawY,
    input blank,
    input hs,
    input vs,
    input frame_start,
    input frame_count
  );
endinterface

// File: rtl/vga_timing_gen.sv
// Raster timing generator: scans an H_TOTAL x V_TOTAL frame one pixel per
// vga_clk, decodes the visible window and the sync pulses, and delays the
// syncs so they line up with drawer colour that lags the coordinates.
module vga_timing_gen #(
  parameter int H_VISIBLE  = 640,
  parameter int H_FRONT    = 16,
  parameter int H_SYNC     = 96,
  parameter int H_BACK     = 48,
  parameter int V_VISIBLE  = 480,
  parameter int V_FRONT    = 10,
  parameter int V_SYNC     = 2,
  parameter int V_BACK     = 33,
  parameter int SYNC_DELAY = 2
) (
  input logic vga_clk,
  input logic reset,
  vga_timing_gen_if.master vga
);

  localparam int H_TOTAL = H_VISIBLE + H_FRONT + H_SYNC + H_BACK;
  localparam int V_TOTAL = V_VISIBLE + V_FRONT + V_SYNC + V_BACK;

  localparam logic [9:0] H_LAST = 10'(H_TOTAL - 1);
  localparam logic [9:0] V_LAST = 10'(V_TOTAL - 1);

  // Decode bounds are 11 bits wide so an end bound of 1024 still compares
  // correctly against the zero-extended 10-bit counters.
  localparam logic [10:0] H_VIS_END  = 11'(H_VISIBLE);
  localparam logic [10:0] V_VIS_END  = 11'(V_VISIBLE);
  localparam logic [10:0] HS_START   = 11'(H_VISIBLE + H_FRONT);
  localparam logic [10:0] HS_END     = 11'(H_VISIBLE + H_FRONT + H_SYNC);
  localparam logic [10:0] VS_START   = 11'(V_VISIBLE + V_FRONT);
  localparam logic [10:0] VS_END     = 11'(V_VISIBLE + V_FRONT + V_SYNC);

  logic [9:0] draw_x_reg;
  logic [9:0] draw_y_reg;
  logic       frame_start_reg;
  logic [7:0] frame_count_reg;

  logic h_wrap;
  logic v_wrap;
  logic hsync_raw;
  logic vsync_raw;
  logic blank_dec;
  logic hs_out;
  logic vs_out;

  assign h_wrap = (draw_x_reg == H_LAST);
  assign v_wrap = (draw_y_reg == V_LAST);

  // Horizontal counter runs every cycle; vertical advances on each line wrap
  always_ff @(posedge vga_clk or posedge reset) begin
    if (reset) begin
      draw_x_reg <= 10'd0;
      draw_y_reg <= 10'd0;
    end else if (h_wrap) begin
      draw_x_reg <= 10'd0;
      draw_y_reg <= v_wrap ? 10'd0 : draw_y_reg + 10'd1;
    end else begin
      draw_x_reg <= draw_x_reg + 10'd1;
    end
  end

  // Frame strobe fires on the edge that wraps the raster back to (0,0),
  // so it is seen together with the new frame count in the (0,0) cycle
  always_ff @(posedge vga_clk or posedge reset) begin
    if (reset) begin
      frame_start_reg <= 1'b0;
      frame_count_reg <= 8'd0;
    end else begin
      frame_start_reg <= h_wrap && v_wrap;
      if (h_wrap && v_wrap) begin
        frame_count_reg <= frame_count_reg + 8'd1;
      end
    end
  end

  // Visible window and undelayed active-low sync pulses from the counters
  always_comb begin
    blank_dec = ({1'b0, draw_x_reg} < H_VIS_END) && ({1'b0, draw_y_reg} < V_VIS_END);
    hsync_raw = !(({1'b0, draw_x_reg} >= HS_START) && ({1'b0, draw_x_reg} < HS_END));
    vsync_raw = !(({1'b0, draw_y_reg} >= VS_START) && ({1'b0, draw_y_reg} < VS_END));
  end

  generate
    if (SYNC_DELAY == 0) begin : g_no_delay
      assign hs_out = hsync_raw;
      assign vs_out = vsync_raw;
    end else begin : g_delay
      logic [SYNC_DELAY-1:0] hs_pipe_reg;
      logic [SYNC_DELAY-1:0] vs_pipe_reg;

      // Shift the raw syncs so they match the drawer colour latency; the
      // idle (high) level is preloaded so no false pulse follows reset
      always_ff @(posedge vga_clk or posedge reset) begin
        if (reset) begin
          hs_pipe_reg <= '1;
          vs_pipe_reg <= '1;
        end else begin
          hs_pipe_reg <= SYNC_DELAY'({hs_pipe_reg, hsync_raw});
          vs_pipe_reg <= SYNC_DELAY'({vs_pipe_reg, vsync_raw});
        end
      end

      assign hs_out = hs_pipe_reg[SYNC_DELAY-1];
      assign vs_out = vs_pipe_reg[SYNC_DELAY-1];
    end
  endgenerate

  assign vga.DrawX       = draw_x_reg;
  assign vga.DrawY       = draw_y_reg;
  assign vga.blank       = blank_dec;
  assign vga.hs          = hs_out;
  assign vga.vs          = vs_out;
  assign vga.frame_start = frame_start_reg;
  assign vga.frame_count = frame_count_reg;

endmodule

// File: tb/tb_vga_timing_gen.sv
// Bench for vga_timing_gen: a small-raster instance exercises frame-level
// behaviour quickly, a default-parameter instance checks real 640x480 line
// timing. Expected values come from a cycle-count model of the raster.
module tb_vga_timing_gen;

  // Small raster: 15 x 8 = 120 cycles per frame, sync delay 3
  localparam int SHV = 8, SHF = 2, SHS = 3, SHB = 2;
  localparam int SVV = 4, SVF = 1, SVS = 2, SVB = 1;
  localparam int SD  = 3;
  localparam int SHT = SHV + SHF + SHS + SHB;
  localparam int SFT = SHT * (SVV + SVF + SVS + SVB);

  // Default raster
  localparam int DHV = 640, DHF = 16, DHS = 96, DHB = 48;
  localparam int DVV = 480, DVF = 10, DVS = 2, DVB = 33;
  localparam int DD  = 2;
  localparam int DHT = DHV + DHF + DHS + DHB;

  localparam logic [30:0] RST_WORD = {10'd0, 10'd0, 1'b1, 1'b1, 1'b1, 1'b0, 8'd0};

  logic vga_clk = 1'b0;
  logic reset   = 1'b1;

  vga_timing_gen_if vif_s ();
  vga_timing_gen_if vif_d ();

  vga_timing_gen #(
    .H_VISIBLE(SHV), .H_FRONT(SHF), .H_SYNC(SHS), .H_BACK(SHB),
    .V_VISIBLE(SVV), .V_FRONT(SVF), .V_SYNC(SVS), .V_BACK(SVB),
    .SYNC_DELAY(SD)
  ) dut_s (
    .vga_clk(vga_clk),
    .reset(reset),
    .vga(vif_s)
  );

  vga_timing_gen dut_d (
    .vga_clk(vga_clk),
    .reset(reset),
    .vga(vif_d)
  );

  int checks   = 0;
  int failures = 0;
  longint t;

  always #5 vga_clk = ~vga_clk;

  // Rising edges seen since reset was last released
  always @(posedge vga_clk or posedge reset) begin
    if (reset) t <= 0;
    else       t <= t + 1;
  end

  wire [30:0] obs_s = {vif_s.DrawX, vif_s.DrawY, vif_s.blank, vif_s.hs, vif_s.vs,
                       vif_s.frame_start, vif_s.frame_count};
  wire [30:0] obs_d = {vif_d.DrawX, vif_d.DrawY, vif_d.blank, vif_d.hs, vif_d.vs,
                       vif_d.frame_start, vif_d.frame_count};

  // Raster state expected tt cycles after reset, from plain arithmetic
  function automatic logic [30:0] model(longint tt, int hv, int hf, int hsw, int hb,
                                        int vv, int vf, int vsw, int vb, int d);
    int ht, vt, ft, x, y, sx, sy;
    logic bl, h, v, fs;
    logic [7:0] fc;
    ht = hv + hf + hsw + hb;
    vt = vv + vf + vsw + vb;
    ft = ht * vt;
    x  = int'(tt % ht);
    y  = int'((tt / ht) % vt);
    bl = (x < hv) && (y < vv);
    if (tt < d) begin
      h = 1'b1;
      v = 1'b1;
    end else begin
      sx = int'((tt - d) % ht);
      sy = int'(((tt - d) / ht) % vt);
      h  = !((sx >= hv + hf) && (sx < hv + hf + hsw));
      v  = !((sy >= vv + vf) && (sy < vv + vf + vsw));
    end
    fs = (tt > 0) && (tt % ft == 0);
    fc = 8'((tt / ft) % 256);
    return {10'(x), 10'(y), bl, h, v, fs, fc};
  endfunction

  function automatic logic [30:0] model_s(longint tt);
    return model(tt, SHV, SHF, SHS, SHB, SVV, SVF, SVS, SVB, SD);
  endfunction

  function automatic logic [30:0] model_d(longint tt);
    return model(tt, DHV, DHF, DHS, DHB, DVV, DVF, DVS, DVB, DD);
  endfunction

  task automatic test_reset();
    reset = 1'b1;
    repeat (5) @(posedge vga_clk);
    @(negedge vga_clk);
    checks++;
    if (obs_s !== RST_WORD) begin
      failures++;
      $display("FAIL reset_small actual=%h expected=%h", obs_s, RST_WORD);
    end
    checks++;
    if (obs_d !== RST_WORD) begin
      failures++;
      $display("FAIL reset_default actual=%h expected=%h", obs_d, RST_WORD);
    end
    reset = 1'b0;
    @(negedge vga_clk);
    checks++;
    if (vif_d.DrawX !== 10'd1) begin
      failures++;
      $display("FAIL first_edge_drawx actual=%0d expected=1", vif_d.DrawX);
    end
    $display("test_reset done checks=%0d failures=%0d", checks, failures);
  endtask

  task automatic test_random_window(input int n);
    logic [30:0] exp_s, exp_d;
    for (int i = 0; i < n; i++) begin
      @(negedge vga_clk);
      exp_s = model_s(t);
      exp_d = model_d(t);
      checks++;
      if (obs_s !== exp_s) begin
        failures++;
        $display("FAIL model_small t=%0d actual=%h expected=%h", t, obs_s, exp_s);
      end
      checks++;
      if (obs_d !== exp_d) begin
        failures++;
        $display("FAIL model_default t=%0d actual=%h expected=%h", t, obs_d, exp_d);
      end
    end
    $display("test_random_window cycles=%0d checks=%0d failures=%0d", n, checks, failures);
  endtask

  task automatic test_hsync_line();
    int low_cnt = 0, first_low = -1, rise_x = -1, y_before = -1, guard = 0;
    logic prev_hs = 1'b1;
    @(negedge vga_clk);
    while (vif_d.DrawX !== 10'd0 && guard < DHT + 2) begin
      @(negedge vga_clk);
      guard++;
    end
    checks++;
    if (vif_d.DrawX !== 10'd0) begin
      failures++;
      $display("FAIL hsync_line_start_timeout actual=%0d expected=0", vif_d.DrawX);
    end else begin
      for (int i = 0; i <= DHT; i++) begin
        if (i > 0) @(negedge vga_clk);
        if (!vif_d.hs) begin
          low_cnt++;
          if (first_low < 0) first_low = int'(vif_d.DrawX);
        end else if (!prev_hs && rise_x < 0) begin
          rise_x = int'(vif_d.DrawX);
        end
        prev_hs = vif_d.hs;
        if (vif_d.DrawX == 10'd639) begin
          checks++;
          if (vif_d.blank !== 1'b1) begin
            failures++;
            $display("FAIL blank_x639 actual=%b expected=1", vif_d.blank);
          end
        end
        if (vif_d.DrawX == 10'd640) begin
          checks++;
          if (vif_d.blank !== 1'b0) begin
            failures++;
            $display("FAIL blank_x640 actual=%b expected=0", vif_d.blank);
          end
        end
        if (i == DHT - 1) y_before = int'(vif_d.DrawY);
      end
      checks++;
      if (vif_d.DrawX !== 10'd0 || int'(vif_d.DrawY) != y_before + 1) begin
        failures++;
        $display("FAIL line_wrap actual=(%0d,%0d) expected=(0,%0d)",
                 vif_d.DrawX, vif_d.DrawY, y_before + 1);
      end
      checks++;
      if (low_cnt != DHS) begin
        failures++;
        $display("FAIL hs_low_len actual=%0d expected=%0d", low_cnt, DHS);
      end
      checks++;
      if (first_low != DHV + DHF + DD) begin
        failures++;
        $display("FAIL hs_first_low actual=%0d expected=%0d", first_low, DHV + DHF + DD);
      end
      checks++;
      if (rise_x != DHV + DHF + DHS + DD) begin
        failures++;
        $display("FAIL hs_rise actual=%0d expected=%0d", rise_x, DHV + DHF + DHS + DD);
      end
    end
    $display("test_hsync_line low=%0d first=%0d rise=%0d", low_cnt, first_low, rise_x);
  endtask

  task automatic test_vsync_frame();
    int low_cnt = 0, fx = -1, fy = -1, blank_bad = 0, guard = 0;
    @(negedge vga_clk);
    while (vif_s.frame_start !== 1'b1 && guard < 2 * SFT) begin
      @(negedge vga_clk);
      guard++;
    end
    checks++;
    if (vif_s.frame_start !== 1'b1) begin
      failures++;
      $display("FAIL vsync_frame_start_timeout actual=%b expected=1", vif_s.frame_start);
    end else begin
      for (int i = 0; i < SFT; i++) begin
        if (i > 0) @(negedge vga_clk);
        if (!vif_s.vs) begin
          low_cnt++;
          if (fx < 0) begin
            fx = int'(vif_s.DrawX);
            fy = int'(vif_s.DrawY);
          end
        end
        if (int'(vif_s.DrawY) >= SVV && vif_s.blank !== 1'b0) blank_bad++;
      end
      checks++;
      if (low_cnt != SVS * SHT) begin
        failures++;
        $display("FAIL vs_low_len actual=%0d expected=%0d", low_cnt, SVS * SHT);
      end
      checks++;
      if (fx != SD || fy != SVV + SVF) begin
        failures++;
        $display("FAIL vs_first_low actual=(%0d,%0d) expected=(%0d,%0d)", fx, fy, SD, SVV + SVF);
      end
      checks++;
      if (blank_bad != 0) begin
        failures++;
        $display("FAIL blank_vertical_porch actual=%0d expected=0", blank_bad);
      end
    end
    $display("test_vsync_frame low=%0d first=(%0d,%0d)", low_cnt, fx, fy);
  endtask

  task automatic test_reset_midframe();
    int wait_cycles;
    wait_cycles = $urandom_range(30, 2 * SFT);
    repeat (wait_cycles) @(negedge vga_clk);
    #1;
    reset = 1'b1;
    #1;
    checks++;
    if (obs_s !== RST_WORD) begin
      failures++;
      $display("FAIL midframe_reset_small actual=%h expected=%h", obs_s, RST_WORD);
    end
    checks++;
    if (obs_d !== RST_WORD) begin
      failures++;
      $display("FAIL midframe_reset_default actual=%h expected=%h", obs_d, RST_WORD);
    end
    @(negedge vga_clk);
    reset = 1'b0;
    $display("test_reset_midframe after=%0d cycles", wait_cycles);
  endtask

  task automatic test_frames();
    int pulses = 0;
    for (int i = 0; i < 3 * SFT + 5; i++) begin
      @(negedge vga_clk);
      if (vif_s.frame_start) begin
        pulses++;
        checks++;
        if (t != longint'(pulses * SFT)) begin
          failures++;
          $display("FAIL frame_start_time actual=%0d expected=%0d", t, pulses * SFT);
        end
        checks++;
        if (vif_s.frame_count !== 8'(pulses)) begin
          failures++;
          $display("FAIL frame_count actual=%0d expected=%0d", vif_s.frame_count, pulses);
        end
        checks++;
        if (vif_s.DrawX !== 10'd0 || vif_s.DrawY !== 10'd0) begin
          failures++;
          $display("FAIL frame_start_pos actual=(%0d,%0d) expected=(0,0)", vif_s.DrawX, vif_s.DrawY);
        end
      end
    end
    checks++;
    if (pulses != 3) begin
      failures++;
      $display("FAIL frame_start_count actual=%0d expected=3", pulses);
    end
    $display("test_frames pulses=%0d", pulses);
  endtask

  task automatic test_count_wrap();
    int guard = 0;
    @(negedge vga_clk);
    while (vif_s.frame_count !== 8'd255 && guard < 300 * SFT) begin
      @(negedge vga_clk);
      guard++;
    end
    checks++;
    if (vif_s.frame_count !== 8'd255) begin
      failures++;
      $display("FAIL count_reach_255 actual=%0d expected=255", vif_s.frame_count);
    end else begin
      guard = 0;
      @(negedge vga_clk);
      while (vif_s.frame_start !== 1'b1 && guard < 2 * SFT) begin
        @(negedge vga_clk);
        guard++;
      end
      checks++;
      if (vif_s.frame_start !== 1'b1 || vif_s.frame_count !== 8'd0) begin
        failures++;
        $display("FAIL count_wrap actual=fs%b/fc%0d expected=fs1/fc0",
                 vif_s.frame_start, vif_s.frame_count);
      end
    end
    $display("test_count_wrap frame_count=%0d", vif_s.frame_count);
  endtask

  initial begin
    test_reset();
    test_random_window($urandom_range(400, 900));
    test_hsync_line();
    test_vsync_frame();
    test_reset_midframe();
    test_frames();
    test_count_wrap();
    test_random_window($urandom_range(200, 500));
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
